alu_execute_stage: RTL and testbench
====================================

# alu_execute_stage

Execute stage directly downstream of the shifter/sign-extender. Each cycle it accepts one decoded instruction: the IR, the Rn operand, and the shifter's 32-bit operand and carry-out. It evaluates the condition code against the committed NZCV flags, computes the ALU result, updates the status-flag register, and presents a registered result for writeback. The stage uses a valid/ready handshake on both sides. Its C flag feeds the shifter's carry-in.

## Interface
Parameters:
- DATA_W, 32, datapath width; fixed at 32, no other value supported.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept; equals !out_valid || out_ready.
- ir  in  32  instruction word.
- rn  in  32  first operand; the PC for branches.
- shifter_op  in  32  shifter/sign-extender output.
- shifter_cout  in  1  shifter carry-out.
- out_valid  out  1  result register holds a valid instruction.
- out_ready  in  1  writeback consumes the result.
- result  out  32  registered ALU result.
- rd  out  4  destination register, ir[15:12].
- wr_en  out  1  register writeback required.
- cond_pass  out  1  the captured instruction's condition passed.
- flags  out  4  committed {N,Z,C,V}; flags[1] drives the shifter's cIn.

## Operation
- Accept occurs when in_valid && in_ready. On accept, result, rd, wr_en, cond_pass and out_valid load on the same edge. Flags update on that same edge only when enabled (see below).
- Condition check on ir[31:28] uses the committed flags:
  - EQ…LE per ARM.
  - AL (1110) always passes.
  - 1111 never passes.
- Data processing: ir[27:26]=00. The opcode in ir[24:21] selects one of the 16 ARM operations with op2 = shifter_op.
  - ADC, SBC and RSC use the committed C.
  - Subtraction is rn + ~op2 + 1; C is the carry-out, i.e. NOT borrow.
  - wr_en = cond_pass && opcode not in {TST, TEQ, CMP, CMN}.
  - Flag update occurs when cond_pass && (S=ir[20]).
  - N = result[31]; Z = (result == 0).
  - Logical ops: C = shifter_cout, V unchanged.
  - Arithmetic ops: C = adder carry, V = signed overflow.
  - Rd=15 with S set is treated as an ordinary flag update.
- Load/store: ir[27:26]=01. result = ir[23] ? rn+shifter_op : rn−shifter_op. wr_en=0; flags unchanged.
- Branch: ir[27:25]=101. result = rn+shifter_op. wr_en=0; flags unchanged.
- Any other encoding: result = shifter_op, wr_en=0, flags unchanged.
- When the condition fails, result is still computed and registered, but wr_en=0 and flags hold.
- Back-to-back flag dependency needs no stall: instruction k+1 is checked against the flags written by instruction k on the accept edge of k.

## Timing
- Reset (async, immediate on reset_n low):
  - out_valid=0, result=0, rd=0, wr_en=0, cond_pass=0, flags=4'b0000.
  - in_ready=1 once reset_n is high.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 instruction per cycle while out_ready=1.
- out_valid && !out_ready → all outputs hold and in_ready=0; upstream must hold its inputs.
- A simultaneous accept and consume replaces the result in the same cycle with no bubble.
- No accept while out_ready=1 → out_valid clears next cycle.
- Reset mid-operation drops the in-flight result. Flags are lost and return to 0000.

## Structure
- Shared package arm_pkg holds:
  - the 16 data-processing opcode constants;
  - the 15 condition-code constants;
  - flag bit indices N=3, Z=2, C=1, V=0;
  - instruction-class field constants.
- Sub-module cond_check: combinational, inputs cond[3:0] and flags[3:0], output pass. Reusable by the control unit.
- ALU arithmetic and logic live inline in alu_execute_stage.

## Test plan
- Reset: assert reset_n=0 while out_valid=1 and flags=0110 → out_valid=0 and flags=0000 with no clock edge; in_ready=1 after release.
- ADDS r0,r1,r2 (ir=0xE0910002), rn=0x7FFFFFFF, shifter_op=1 → next cycle result=0x80000000, rd=0, wr_en=1, flags=1001.
- SUBS r0,r1,r2 (ir=0xE0510002), rn=5, shifter_op=5 → result=0, flags=0110.
- Immediately follow with MOVNE r3,#1 (ir=0x13A03001), shifter_op=1 → cond_pass=0, wr_en=0, result=1, flags stay 0110.
- TST r1,r2 (ir=0xE1110002), rn=0xF0, shifter_op=0x0F, shifter_cout=1, prior V=1 → result=0, wr_en=0, flags=0111.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and in_valid=1 → in_ready=0 and result/flags stable. Raise out_ready → old result consumed and new instruction accepted on the same edge; next result appears 1 cycle later.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM execute-side definitions: opcodes, condition codes,
// flag bit positions and instruction-class fields.
package arm_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_EOR = 4'h1,
        OP_SUB = 4'h2,
        OP_RSB = 4'h3,
        OP_ADD = 4'h4,
        OP_ADC = 4'h5,
        OP_SBC = 4'h6,
        OP_RSC = 4'h7,
        OP_TST = 4'h8,
        OP_TEQ = 4'h9,
        OP_CMP = 4'hA,
        OP_CMN = 4'hB,
        OP_ORR = 4'hC,
        OP_MOV = 4'hD,
        OP_BIC = 4'hE,
        OP_MVN = 4'hF
    } dp_op_e;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] CLS_DP = 2'b00;
    localparam logic [1:0] CLS_LS = 2'b01;
    localparam logic [2:0] CLS_BR = 3'b101;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  rd;
        logic        wr_en;
        logic        cond_pass;
    } ex_wb_t;

    function automatic logic is_test_op(input dp_op_e op);
        return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluator against committed NZCV.
// Purely combinational; 1111 never passes.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_execute_stage.sv
// Execute stage: condition check, ALU, NZCV register and
// registered writeback bundle behind a valid/ready handshake.
module alu_execute_stage
    import arm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       ir,
    input  logic [DATA_W-1:0] rn,
    input  logic [DATA_W-1:0] shifter_op,
    input  logic              shifter_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        rd,
    output logic              wr_en,
    output logic              cond_pass,
    output logic [3:0]        flags
);

    logic [3:0]        flags_q;
    ex_wb_t            wb_q;
    ex_wb_t            wb_d;
    logic              valid_q;
    logic              pass;
    logic              accept;
    dp_op_e            op;
    logic              is_dp, is_ls, is_br;
    logic              arith;
    logic              flag_upd;
    logic [DATA_W-1:0] add_a, add_b;
    logic              add_ci;
    logic [DATA_W:0]   sum;
    logic              ovf;
    logic [DATA_W-1:0] logic_res;
    logic [DATA_W-1:0] dp_res;
    logic [3:0]        flags_d;
    logic              unused_ir;

    assign unused_ir = ^{ir[19:16], ir[11:0]};

    cond_check u_cond (
        .cond  (ir[31:28]),
        .flags (flags_q),
        .pass  (pass)
    );

    assign op    = dp_op_e'(ir[24:21]);
    assign is_dp = (ir[27:26] == CLS_DP);
    assign is_ls = (ir[27:26] == CLS_LS);
    assign is_br = (ir[27:25] == CLS_BR);

    // Every arithmetic op is one adder; subtracts invert an operand
    // so C comes out as NOT borrow.
    always_comb begin
        add_a  = rn;
        add_b  = shifter_op;
        add_ci = 1'b0;
        arith  = 1'b1;
        unique case (op)
            OP_SUB, OP_CMP: begin
                add_b  = ~shifter_op;
                add_ci = 1'b1;
            end
            OP_RSB: begin
                add_a  = ~rn;
                add_ci = 1'b1;
            end
            OP_ADD, OP_CMN: add_ci = 1'b0;
            OP_ADC: add_ci = flags_q[FLAG_C];
            OP_SBC: begin
                add_b  = ~shifter_op;
                add_ci = flags_q[FLAG_C];
            end
            OP_RSC: begin
                add_a  = ~rn;
                add_ci = flags_q[FLAG_C];
            end
            default: arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, add_a} + {1'b0, add_b}
               + {{DATA_W{1'b0}}, add_ci};
    assign ovf = (add_a[DATA_W-1] == add_b[DATA_W-1])
              && (sum[DATA_W-1] != add_a[DATA_W-1]);

    always_comb begin
        logic_res = '0;
        unique case (op)
            OP_AND, OP_TST: logic_res = rn & shifter_op;
            OP_EOR, OP_TEQ: logic_res = rn ^ shifter_op;
            OP_ORR:         logic_res = rn | shifter_op;
            OP_MOV:         logic_res = shifter_op;
            OP_BIC:         logic_res = rn & ~shifter_op;
            OP_MVN:         logic_res = ~shifter_op;
            default:        logic_res = '0;
        endcase
    end

    assign dp_res = arith ? sum[DATA_W-1:0] : logic_res;

    always_comb begin
        wb_d           = '0;
        wb_d.result    = shifter_op;
        wb_d.rd        = ir[15:12];
        wb_d.cond_pass = pass;
        flag_upd       = 1'b0;
        unique case (1'b1)
            is_dp: begin
                wb_d.result = dp_res;
                wb_d.wr_en  = pass && !is_test_op(op);
                flag_upd    = pass && ir[20];
            end
            is_ls: begin
                wb_d.result = ir[23] ? rn + shifter_op
                                     : rn - shifter_op;
            end
            is_br: wb_d.result = rn + shifter_op;
            default: wb_d.result = shifter_op;
        endcase
    end

    always_comb begin
        flags_d         = flags_q;
        flags_d[FLAG_N] = dp_res[DATA_W-1];
        flags_d[FLAG_Z] = (dp_res == '0);
        flags_d[FLAG_C] = arith ? sum[DATA_W] : shifter_cout;
        flags_d[FLAG_V] = arith ? ovf : flags_q[FLAG_V];
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            wb_q    <= '0;
            flags_q <= 4'b0000;
        end else if (accept) begin
            valid_q <= 1'b1;
            wb_q    <= wb_d;
            if (flag_upd)
                flags_q <= flags_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign result    = wb_q.result;
    assign rd        = wb_q.rd;
    assign wr_en     = wb_q.wr_en;
    assign cond_pass = wb_q.cond_pass;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Scoreboard bench for alu_execute_stage: directed vectors,
// backpressure, random traffic against a reference model, async reset.
module tb_alu_execute_stage;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  rd;
        logic        wr;
        logic        cp;
        logic [3:0]  fl;
    } exp_t;

    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -SMAX - 1;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ir;
    logic [31:0] rn;
    logic [31:0] shifter_op;
    logic        shifter_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  rd;
    logic        wr_en;
    logic        cond_pass;
    logic [3:0]  flags;

    exp_t        q[$];
    logic [3:0]  mfl;
    int          npass = 0;
    int          ntot  = 0;

    alu_execute_stage #(.DATA_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ir           (ir),
        .rn           (rn),
        .shifter_op   (shifter_op),
        .shifter_cout (shifter_cout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .rd           (rd),
        .wr_en        (wr_en),
        .cond_pass    (cond_pass),
        .flags        (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic [3:0] d,
                                input logic w, input logic p,
                                input logic [3:0] f);
        exp_t e;
        e.res = r; e.rd = d; e.wr = w; e.cp = p; e.fl = f;
        return e;
    endfunction

    // Returns {C, V, result}
    function automatic logic [33:0] fadd(input logic [31:0] x, y,
                                         input logic ci);
        longint unsigned u;
        longint s;
        longint c64;
        c64 = ci ? 1 : 0;
        u = {32'b0, x} + {32'b0, y} + c64;
        s = longint'($signed(x)) + longint'($signed(y)) + c64;
        return {u[32], (s > SMAX) || (s < SMIN), u[31:0]};
    endfunction

    function automatic logic [33:0] fsub(input logic [31:0] x, y,
                                         input logic ci);
        longint unsigned ux, uy;
        longint s;
        longint b64;
        logic [31:0] r;
        b64 = ci ? 0 : 1;
        ux = {32'b0, x};
        uy = {32'b0, y};
        s = longint'($signed(x)) - longint'($signed(y)) - b64;
        r = x - y - (ci ? 32'd0 : 32'd1);
        return {ux >= uy + b64, (s > SMAX) || (s < SMIN), r};
    endfunction

    function automatic void model(input logic [31:0] i, a, b,
                                  input logic co,
                                  inout logic [3:0] f,
                                  output exp_t e);
        logic n, z, c, v, p, wr, ar;
        logic [31:0] r;
        logic [33:0] t;
        {n, z, c, v} = f;
        case (i[31:28])
            4'h0: p = z;
            4'h1: p = !z;
            4'h2: p = c;
            4'h3: p = !c;
            4'h4: p = n;
            4'h5: p = !n;
            4'h6: p = v;
            4'h7: p = !v;
            4'h8: p = c & !z;
            4'h9: p = !c | z;
            4'hA: p = (n == v);
            4'hB: p = (n != v);
            4'hC: p = !z & (n == v);
            4'hD: p = z | (n != v);
            4'hE: p = 1'b1;
            default: p = 1'b0;
        endcase
        r = b; wr = 1'b0; ar = 1'b1; t = '0;
        if (i[27:26] == 2'b00) begin
            case (i[24:21])
                4'h2, 4'hA: t = fsub(a, b, 1'b1);
                4'h3:       t = fsub(b, a, 1'b1);
                4'h4, 4'hB: t = fadd(a, b, 1'b0);
                4'h5:       t = fadd(a, b, c);
                4'h6:       t = fsub(a, b, c);
                4'h7:       t = fsub(b, a, c);
                default:    ar = 1'b0;
            endcase
            case (i[24:21])
                4'h0, 4'h8: r = a & b;
                4'h1, 4'h9: r = a ^ b;
                4'hC:       r = a | b;
                4'hD:       r = b;
                4'hE:       r = a & ~b;
                4'hF:       r = ~b;
                default:    r = t[31:0];
            endcase
            wr = p && !(i[24:21] inside {4'h8, 4'h9, 4'hA, 4'hB});
            if (p && i[20])
                f = {r[31], r == 32'd0, ar ? t[33] : co, ar ? t[32] : v};
        end else if (i[27:26] == 2'b01) begin
            r = i[23] ? a + b : a - b;
        end else if (i[27:25] == 3'b101) begin
            r = a + b;
        end
        e = mk(r, i[15:12], wr, p, f);
    endfunction

    task automatic send(input logic [31:0] i, a, b, input logic co,
                        input bit directed, input exp_t de);
        exp_t e;
        int n;
        ir = i; rn = a; shifter_op = b; shifter_cout = co;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 40) begin
                check("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
        end
        if (directed) begin
            e = de;
            mfl = de.fl;
        end else begin
            model(i, a, b, co, mfl, e);
        end
        @(posedge clk);
        q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("result", result, e.res);
                check("rd", {28'd0, rd}, {28'd0, e.rd});
                check("wr_en", {31'd0, wr_en}, {31'd0, e.wr});
                check("cond_pass", {31'd0, cond_pass}, {31'd0, e.cp});
                check("flags", {28'd0, flags}, {28'd0, e.fl});
            end
        end
    end

    initial begin
        logic [31:0] i;
        logic [3:0]  cnd;
        int          k;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ir = '0; rn = '0; shifter_op = '0; shifter_cout = 1'b0;
        mfl = 4'b0000;
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", {28'd0, rd}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_cond_pass", {31'd0, cond_pass}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1 check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;

        send(32'hE091_0002, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1,
             mk(32'h8000_0000, 4'd0, 1'b1, 1'b1, 4'b1001));
        send(32'hE051_0002, 32'd5, 32'd5, 1'b0, 1'b1,
             mk(32'd0, 4'd0, 1'b1, 1'b1, 4'b0110));
        send(32'h13A0_3001, 32'd0, 32'd1, 1'b0, 1'b1,
             mk(32'd1, 4'd3, 1'b0, 1'b0, 4'b0110));
        send(32'hE091_0002, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1,
             mk(32'h8000_0000, 4'd0, 1'b1, 1'b1, 4'b1001));
        send(32'hE111_0002, 32'h0000_00F0, 32'h0000_000F, 1'b1, 1'b1,
             mk(32'd0, 4'd0, 1'b0, 1'b1, 4'b0111));

        // Hold writeback off with a new instruction waiting.
        out_ready = 1'b0;
        ir = 32'hE591_2004; rn = 32'h1000; shifter_op = 32'd4;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result", result, 32'd0);
            check("bp_flags", {28'd0, flags}, 32'b0111);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'hE591_2004, 32'h1000, 32'd4, 1'b0, 1'b1,
             mk(32'h1004, 4'd2, 1'b0, 1'b1, 4'b0111));
        send(32'hE511_2004, 32'h1000, 32'd4, 1'b0, 1'b1,
             mk(32'h0FFC, 4'd2, 1'b0, 1'b1, 4'b0111));
        send(32'hEA00_0010, 32'h100, 32'h40, 1'b0, 1'b1,
             mk(32'h140, 4'd0, 1'b0, 1'b1, 4'b0111));
        send(32'hEE00_5000, 32'h100, 32'hABCD, 1'b0, 1'b1,
             mk(32'hABCD, 4'd5, 1'b0, 1'b1, 4'b0111));
        send(32'hF091_0002, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1,
             mk(32'h8000_0000, 4'd0, 1'b0, 1'b0, 4'b0111));

        for (int n = 0; n < 150; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            cnd = 4'($urandom_range(0, 15));
            k = $urandom_range(0, 9);
            i = $urandom;
            if (k < 7)       i = {cnd, 2'b00, i[25:0]};
            else if (k == 7) i = {cnd, 2'b01, i[25:0]};
            else if (k == 8) i = {cnd, 3'b101, i[24:0]};
            else             i = {cnd, 2'b11, i[25:0]};
            send(i, pick(), pick(), 1'($urandom_range(0, 1)), 1'b0, '0);
        end

        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("sb_drain", q.size(), 32'd0);

        // Reset with a held result and live flags.
        out_ready = 1'b0;
        send(32'hE051_0002, 32'd5, 32'd5, 1'b0, 1'b1,
             mk(32'd0, 4'd0, 1'b1, 1'b1, 4'b0110));
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_flags", {28'd0, flags}, 32'b0110);
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_flags", {28'd0, flags}, 32'd0);
        check("arst_wr_en", {31'd0, wr_en}, 32'd0);
        q.delete();
        mfl = 4'b0000;
        #2 reset_n = 1'b1;
        #1 check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'h0091_0002, 32'h1, 32'h1, 1'b0, 1'b1,
             mk(32'h2, 4'd0, 1'b0, 1'b0, 4'b0000));
        repeat (3) @(posedge clk);
        #1 check("final_drain", q.size(), 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
